// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master controller:
//   - spi_state_e : controller FSM state encoding
//   - CPOL / CPHA : SPI mode constants (mode 0), packed into SPI_MODE
//   - cs_width()  : width of a chip-select index for a given chip-select count
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // Mode 0: SCLK idles low, data is sampled on the leading (rising) edge
    // and changed on the trailing (falling) edge.
    localparam logic       CPOL     = 1'b0;
    localparam logic       CPHA     = 1'b0;
    localparam logic [1:0] SPI_MODE = {CPOL, CPHA};

    // A single chip select still needs a 1-bit index port.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
// Request/response bus between a client and the SPI master controller.
//   start   : client -> ctrl  transfer request
//   tx_data : client -> ctrl  frame to send, MSB first
//   cs_sel  : client -> ctrl  target slave index
//   busy    : ctrl -> client  frame in progress (accept cycle + 1 .. done cycle)
//   done    : ctrl -> client  one-cycle completion pulse
//   rx_data : ctrl -> client  last received frame, held until the next done
//
// Handshake: start acts as "valid" and (!busy && !done) as "ready". A request
// is taken on the rising clk edge where start=1 while the controller is idle;
// tx_data/cs_sel are captured on that edge only. start seen while busy or in
// the done cycle is dropped, so a client that holds start high is served
// again in the first idle cycle after done.
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CS = 2
) ();

    localparam int CS_W = spi_pkg::cs_width(NUM_CS);

    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic [CS_W-1:0]  cs_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;

    // Client side.
    modport master (
        output start, tx_data, cs_sel,
        input  busy, done, rx_data
    );

    // Controller side.
    modport slave (
        input  start, tx_data, cs_sel,
        output busy, done, rx_data
    );

endinterface

// File: rtl/spi_tick_gen.sv
// ---------------------------------------------------------------------------
// spi_tick_gen
// Divides clk down to one tick per DIVISOR cycles; each tick marks an SCLK
// half-period boundary for the controller.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear of the count (takes priority over en)
//   en    : count enable; the count holds while low
//   tick  : high for the one cycle where the count sits at DIVISOR-1
// ---------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int DIVISOR = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// Single-frame SPI master, mode 0. A request on the bus selects one slave,
// shifts WIDTH bits out on mosi (MSB first) while shifting WIDTH bits in from
// miso, then releases the chip select and reports the received frame.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/response bus (start, tx_data, cs_sel, busy, done,
//               rx_data), controller side
//   miso      : serial data in
//   sclk      : SPI clock, idles low
//   mosi      : serial data out, 0 when idle
//   cs_n      : active-low chip selects, at most one low
//   state_dbg : current FSM state
//
// Frame timing, counted in SCLK half-periods of DIVISOR clk cycles each:
// SETUP (1), WIDTH high/low pairs in SHIFT (2*WIDTH), one low half-period
// after the last falling edge (the SHIFT->HOLD step), HOLD (1). The done
// cycle therefore lands (2*WIDTH+2)*DIVISOR+1 cycles after the accept edge.
// ---------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DIVISOR = 4,
    parameter int WIDTH   = 8,
    parameter int NUM_CS  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.slave  bus,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output spi_state_e        state_dbg
);

    localparam int            CS_W      = cs_width(NUM_CS);
    localparam int            BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH);
    localparam logic          SCLK_IDLE = SPI_MODE[1];

    spi_state_e       state;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_q;
    logic [BW-1:0]    bit_cnt;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             tick_clr;
    logic             tick_en;

    // Out-of-range selects decode to "no slave": the frame still runs.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(sel) == i) begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // The divider restarts at the accept edge so every frame has the same
    // phase, and it is frozen while idle or reporting.
    assign tick_clr = (state == ST_IDLE) && bus.start;
    assign tick_en  = (state != ST_IDLE) && (state != ST_DONE);

    spi_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sclk     <= SCLK_IDLE;
            mosi     <= 1'b0;
            cs_n     <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rx_q     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // The MSB goes out with the chip select so it is
                        // stable well before the first rising edge.
                        mosi     <= bus.tx_data[WIDTH-1];
                        tx_shift <= {bus.tx_data[WIDTH-2:0], 1'b0};
                        cs_n     <= cs_decode(bus.cs_sel);
                        busy_q   <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (tick) begin
                        sclk     <= ~SCLK_IDLE;
                        rx_shift <= {rx_shift[WIDTH-2:0], miso};
                        bit_cnt  <= BW'(1);
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (tick) begin
                        if (sclk != SCLK_IDLE) begin
                            // Falling edge: present the next bit, except
                            // after the last one where mosi is left alone.
                            sclk <= SCLK_IDLE;
                            if (bit_cnt != LAST_BIT) begin
                                mosi     <= tx_shift[WIDTH-1];
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            end
                        end else if (bit_cnt == LAST_BIT) begin
                            // Last low half-period is over; no more edges.
                            state <= ST_HOLD;
                        end else begin
                            // Rising edge: sample miso.
                            sclk     <= ~SCLK_IDLE;
                            rx_shift <= {rx_shift[WIDTH-2:0], miso};
                            bit_cnt  <= bit_cnt + BW'(1);
                        end
                    end
                end

                ST_HOLD: begin
                    if (tick) begin
                        cs_n   <= '1;
                        mosi   <= 1'b0;
                        rx_q   <= rx_shift;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Bench for spi_master_ctrl. Instance A: DIVISOR=4, WIDTH=8, NUM_CS=2, with
// miso fed either by loopback or by a mode-0 slave returning a fixed word.
// Instance B: DIVISOR=2, WIDTH=16, NUM_CS=3, loopback, used for the fast
// divider, the wide frame and an out-of-range chip select.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int D_A   = 4;
    localparam int W_A   = 8;
    localparam int D_B   = 2;
    localparam int W_B   = 16;
    localparam int LAT_A = (2 * W_A + 2) * D_A + 1;
    localparam int LAT_B = (2 * W_B + 2) * D_B + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    spi_master_ctrl_if #(.WIDTH(W_A), .NUM_CS(2)) bus_a ();
    logic       miso_a, sclk_a, mosi_a;
    logic [1:0] cs_n_a;
    spi_state_e st_a;
    bit         loopback_a = 1'b1;
    logic [7:0] slave_word_a = 8'h00;

    spi_master_ctrl #(.DIVISOR(D_A), .WIDTH(W_A), .NUM_CS(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .miso      (miso_a),
        .sclk      (sclk_a),
        .mosi      (mosi_a),
        .cs_n      (cs_n_a),
        .state_dbg (st_a)
    );

    // ---------------- DUT B ----------------
    spi_master_ctrl_if #(.WIDTH(W_B), .NUM_CS(3)) bus_b ();
    logic       miso_b, sclk_b, mosi_b;
    logic [2:0] cs_n_b;
    spi_state_e st_b;

    spi_master_ctrl #(.DIVISOR(D_B), .WIDTH(W_B), .NUM_CS(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .miso      (miso_b),
        .sclk      (sclk_b),
        .mosi      (mosi_b),
        .cs_n      (cs_n_b),
        .state_dbg (st_b)
    );

    assign miso_b = mosi_b;

    // ---------------- slave model / line monitor for A ----------------
    // Counts SCLK rising edges of the current frame, records mosi at each,
    // and presents the slave word MSB first (next bit after each rising edge).
    int         n_rise_a    = 0;
    logic [7:0] mosi_seen_a = 8'h00;
    logic       sclk_prev_a = 1'b0;

    assign miso_a = loopback_a ? mosi_a
                  : ((n_rise_a < 8) ? slave_word_a[3'(7 - n_rise_a)] : 1'b0);

    always @(negedge clk) begin
        sclk_prev_a <= sclk_a;
        if (bus_a.busy !== 1'b1) begin
            n_rise_a <= 0;
        end else if (sclk_a === 1'b1 && sclk_prev_a === 1'b0) begin
            if (n_rise_a < 8) mosi_seen_a[3'(7 - n_rise_a)] <= mosi_a;
            n_rise_a <= n_rise_a + 1;
        end
    end

    // ---------------- counters and per-frame observations ----------------
    int total = 0;
    int bad   = 0;

    int         r_lat, r_cs_dev, r_busy_low, r_rise;
    logic [1:0] r_cs_first, r_cs_done;
    logic [7:0] r_rx, r_mosi;
    logic       r_done_after, r_busy_after, r_sclk_idle, r_mosi_idle;

    // Reference: the addressed select is the only low bit; none if out of range.
    function automatic logic [1:0] exp_cs_a(input int sel);
        logic [1:0] m;
        m = '1;
        if (sel < 2) m[sel] = 1'b0;
        return m;
    endfunction

    function automatic logic [2:0] exp_cs_b(input int sel);
        logic [2:0] m;
        m = '1;
        if (sel < 3) m[sel] = 1'b0;
        return m;
    endfunction

    // ---------------- driver ----------------
    // Called just after a negedge. Requests one frame on A, scrambles the
    // request inputs right after acceptance, observes until done, then steps
    // one more cycle into idle.
    task automatic run_frame_a(input logic [7:0] tx, input int sel,
                               input logic [7:0] slv, input bit lb);
        loopback_a    = lb;
        slave_word_a  = slv;
        bus_a.start   = 1'b1;
        bus_a.tx_data = tx;
        bus_a.cs_sel  = 1'(sel);
        @(negedge clk);
        bus_a.start   = 1'b0;
        bus_a.tx_data = 8'($urandom);
        bus_a.cs_sel  = 1'($urandom);
        r_lat      = 1;
        r_cs_dev   = 0;
        r_busy_low = 0;
        r_cs_first = cs_n_a;
        while (bus_a.done !== 1'b1 && r_lat < 1000) begin
            if (bus_a.busy !== 1'b1) r_busy_low++;
            if (cs_n_a !== r_cs_first) r_cs_dev++;
            @(negedge clk);
            r_lat++;
        end
        if (bus_a.busy !== 1'b1) r_busy_low++;
        r_rx      = bus_a.rx_data;
        r_cs_done = cs_n_a;
        r_rise    = n_rise_a;
        r_mosi    = mosi_seen_a;
        @(negedge clk);
        r_done_after = bus_a.done;
        r_busy_after = bus_a.busy;
        r_sclk_idle  = sclk_a;
        r_mosi_idle  = mosi_a;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", sclk_a); end
        total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
        total++; if (cs_n_a !== 2'b11) begin bad++; $display("FAIL rst_cs_n: got %b want 11", cs_n_a); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus_a.done); end
        total++; if (bus_a.rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx: got %h want 00", bus_a.rx_data); end
        total++; if (st_a !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", st_a, ST_IDLE); end
        total++; if (cs_n_b !== 3'b111) begin bad++; $display("FAIL rst_cs_n_b: got %b want 111", cs_n_b); end
        bus_a.start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_loopback();
        run_frame_a(8'hA5, 1, 8'h00, 1'b1);
        total++; if (r_lat !== LAT_A) begin bad++; $display("FAIL lb_latency: got %0d want %0d", r_lat, LAT_A); end
        total++; if (r_rx !== 8'hA5) begin bad++; $display("FAIL lb_rx: got %h want a5", r_rx); end
        total++; if (r_cs_first !== 2'b01) begin bad++; $display("FAIL lb_cs_n: got %b want 01", r_cs_first); end
        total++; if (r_cs_dev !== 0) begin bad++; $display("FAIL lb_cs_stable: got %0d changes want 0", r_cs_dev); end
        total++; if (r_rise !== 8) begin bad++; $display("FAIL lb_rising: got %0d want 8", r_rise); end
        total++; if (r_busy_low !== 0) begin bad++; $display("FAIL lb_busy: got %0d low cycles want 0", r_busy_low); end
        total++; if (r_cs_done !== 2'b11) begin bad++; $display("FAIL lb_cs_done: got %b want 11", r_cs_done); end
        total++; if (r_done_after !== 1'b0) begin bad++; $display("FAIL lb_done_width: got %b want 0", r_done_after); end
    endtask

    task automatic test_slave_pattern();
        run_frame_a(8'hC3, 0, 8'h3C, 1'b0);
        total++; if (r_mosi !== 8'hC3) begin bad++; $display("FAIL sp_mosi_bits: got %b want 11000011", r_mosi); end
        total++; if (r_rx !== 8'h3C) begin bad++; $display("FAIL sp_rx: got %h want 3c", r_rx); end
        total++; if (r_cs_first !== 2'b10) begin bad++; $display("FAIL sp_cs_n: got %b want 10", r_cs_first); end
        total++; if (r_lat !== LAT_A) begin bad++; $display("FAIL sp_latency: got %0d want %0d", r_lat, LAT_A); end
        total++; if (r_mosi_idle !== 1'b0) begin bad++; $display("FAIL sp_mosi_idle: got %b want 0", r_mosi_idle); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] tx, slv, want_rx;
            int         sel;
            bit         lb;
            tx  = 8'($urandom);
            slv = 8'($urandom);
            sel = $urandom_range(0, 1);
            lb  = 1'($urandom);
            want_rx = lb ? tx : slv;
            run_frame_a(tx, sel, slv, lb);
            total++; if (r_lat !== LAT_A) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, r_lat, LAT_A); end
            total++; if (r_rx !== want_rx) begin bad++; $display("FAIL rnd%0d_rx: got %h want %h", i, r_rx, want_rx); end
            total++; if (r_mosi !== tx) begin bad++; $display("FAIL rnd%0d_mosi_bits: got %h want %h", i, r_mosi, tx); end
            total++; if (r_cs_first !== exp_cs_a(sel)) begin bad++; $display("FAIL rnd%0d_cs_n: got %b want %b", i, r_cs_first, exp_cs_a(sel)); end
            total++; if (r_cs_dev !== 0) begin bad++; $display("FAIL rnd%0d_cs_stable: got %0d changes want 0", i, r_cs_dev); end
            total++; if (r_busy_low !== 0) begin bad++; $display("FAIL rnd%0d_busy: got %0d low cycles want 0", i, r_busy_low); end
            total++; if (r_rise !== 8) begin bad++; $display("FAIL rnd%0d_rising: got %0d want 8", i, r_rise); end
            total++; if (r_busy_after !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy_idle: got %b want 0", i, r_busy_after); end
            total++; if (r_sclk_idle !== 1'b0) begin bad++; $display("FAIL rnd%0d_sclk_idle: got %b want 0", i, r_sclk_idle); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] t1, t2;
        int         lat;
        t1 = 8'($urandom);
        t2 = 8'($urandom);
        loopback_a    = 1'b1;
        bus_a.start   = 1'b1;
        bus_a.tx_data = t1;
        bus_a.cs_sel  = 1'b0;
        @(negedge clk);
        bus_a.start = 1'b0;
        lat = 1;
        while (bus_a.done !== 1'b1 && lat < 1000) begin
            if (lat == 10) begin
                bus_a.start   = 1'b1;
                bus_a.tx_data = ~t1;
                bus_a.cs_sel  = 1'b1;
            end else begin
                bus_a.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_A); end
        total++; if (bus_a.rx_data !== t1) begin bad++; $display("FAIL b2b_first_rx: got %h want %h", bus_a.rx_data, t1); end
        // Raise start in the done cycle and keep it high.
        bus_a.start   = 1'b1;
        bus_a.tx_data = t2;
        bus_a.cs_sel  = 1'b1;
        @(negedge clk);
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", bus_a.busy); end
        total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL b2b_single_done: got %b want 0", bus_a.done); end
        @(negedge clk);
        bus_a.start = 1'b0;
        total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept: got busy %b want 1", bus_a.busy); end
        total++; if (cs_n_a !== 2'b01) begin bad++; $display("FAIL b2b_cs_n: got %b want 01", cs_n_a); end
        lat = 1;
        while (bus_a.done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== LAT_A) begin bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT_A); end
        total++; if (bus_a.rx_data !== t2) begin bad++; $display("FAIL b2b_second_rx: got %h want %h", bus_a.rx_data, t2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] tx;
        int         lat;
        tx = 8'($urandom);
        loopback_a    = 1'b1;
        bus_a.start   = 1'b1;
        bus_a.tx_data = tx;
        bus_a.cs_sel  = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        lat = 1;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rst_n = 1'b0;
        #1;
        total++; if (cs_n_a !== 2'b11) begin bad++; $display("FAIL midrst_cs_n: got %b want 11", cs_n_a); end
        total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL midrst_sclk: got %b want 0", sclk_a); end
        total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus_a.busy); end
        total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL midrst_mosi: got %b want 0", mosi_a); end
        total++; if (bus_a.rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx: got %h want 00", bus_a.rx_data); end
        repeat (3) begin
            @(negedge clk);
            total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL midrst_no_done: got %b want 0", bus_a.done); end
        end
        rst_n = 1'b1;
        tx = 8'($urandom);
        run_frame_a(tx, 0, 8'h00, 1'b1);
        total++; if (r_lat !== LAT_A) begin bad++; $display("FAIL midrst_next_latency: got %0d want %0d", r_lat, LAT_A); end
        total++; if (r_rx !== tx) begin bad++; $display("FAIL midrst_next_rx: got %h want %h", r_rx, tx); end
    endtask

    task automatic test_div2_w16();
        for (int f = 0; f < 3; f++) begin
            logic [15:0] tx;
            logic [2:0]  want_cs;
            int          sel, lat, rises, high, per_bad, last_rise, cs_bad;
            logic        prev;
            sel = (f == 0) ? 3 : $urandom_range(0, 2);
            tx  = 16'($urandom);
            want_cs = exp_cs_b(sel);
            bus_b.start   = 1'b1;
            bus_b.tx_data = tx;
            bus_b.cs_sel  = 2'(sel);
            @(negedge clk);
            bus_b.start   = 1'b0;
            bus_b.tx_data = 16'($urandom);
            bus_b.cs_sel  = 2'($urandom);
            lat = 1; rises = 0; high = 0; per_bad = 0; last_rise = 0; cs_bad = 0;
            prev = 1'b0;
            while (bus_b.done !== 1'b1 && lat < 1000) begin
                if (sclk_b === 1'b1) high++;
                if (sclk_b === 1'b1 && prev === 1'b0) begin
                    if (rises > 0 && (lat - last_rise) != 2 * D_B) per_bad++;
                    last_rise = lat;
                    rises++;
                end
                prev = sclk_b;
                if (cs_n_b !== want_cs) cs_bad++;
                @(negedge clk);
                lat++;
            end
            total++; if (lat !== LAT_B) begin bad++; $display("FAIL w16_%0d_latency: got %0d want %0d", f, lat, LAT_B); end
            total++; if (bus_b.rx_data !== tx) begin bad++; $display("FAIL w16_%0d_rx: got %h want %h", f, bus_b.rx_data, tx); end
            total++; if (rises !== W_B) begin bad++; $display("FAIL w16_%0d_rising: got %0d want %0d", f, rises, W_B); end
            total++; if (high !== W_B * D_B) begin bad++; $display("FAIL w16_%0d_duty: got %0d high cycles want %0d", f, high, W_B * D_B); end
            total++; if (per_bad !== 0) begin bad++; $display("FAIL w16_%0d_period: got %0d bad periods want 0", f, per_bad); end
            total++; if (cs_bad !== 0) begin bad++; $display("FAIL w16_%0d_cs_n: got %0d cycles off want 0 (sel %0d)", f, cs_bad, sel); end
            @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n         = 1'b0;
        bus_a.start   = 1'b0;
        bus_a.tx_data = '0;
        bus_a.cs_sel  = '0;
        bus_b.start   = 1'b0;
        bus_b.tx_data = '0;
        bus_b.cs_sel  = '0;
        test_reset();
        test_loopback();
        test_slave_pattern();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_div2_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
